bcd_scan_display: RTL and testbench

- Downstream consumer of the cascaded BCD counter digits: takes NUM_DIGITS packed 4-bit BCD values and drives a time-multiplexed, common-anode seven-segment display.
- Contains a refresh prescaler, a digit-scan counter and a frame-coherent snapshot register.
- Segment decoding and anode drive are registered, so outputs are glitch-free.
- Sits between the counter chain and the board display pins.

---
 rtl/seg_display_pkg.sv | 35 +++
 rtl/bcd_to_7seg.sv | 13 +
 rtl/bcd_scan_display.sv | 135 +++++++++++++
 tb/tb_bcd_scan_display.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Seven-segment display constants and the BCD-to-segment decode function.
// Segment order is {g,f,e,d,c,b,a}; all patterns are active-low.
package seg_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Codes 10..15 are not BCD; they show a dash rather than raising a flag.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational single-digit BCD to active-low seven-segment decoder.
// Kept separate so a single-digit status display can reuse it.
module bcd_to_7seg
    import seg_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure table lookup; no state.
    assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed common-anode seven-segment driver for NUM_DIGITS BCD digits.
// A prescaler sets how long each digit stays lit, an index scans the digits,
// and the BCD inputs are snapshotted once per frame so the shown value never
// tears. All pin outputs are registered.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zeros).
module bcd_scan_display
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
)
(
    input  logic                      clk,
    input  logic                      Clr,
    input  logic [4*NUM_DIGITS-1:0]   Digits,
    input  logic [NUM_DIGITS-1:0]     DpIn,
    input  logic                      Blank,
    output logic [6:0]                Seg,
    output logic                      Dp,
    output logic [NUM_DIGITS-1:0]     An,
    output logic                      FrameTick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [PW-1:0]           presc_reg;
    logic [IW-1:0]           index_reg;
    logic [4*NUM_DIGITS-1:0] snap_digits_reg;
    logic [NUM_DIGITS-1:0]   snap_dp_reg;
    logic [6:0]              seg_reg;
    logic                    dp_reg;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic                    frame_tick_reg;

    logic                    tick;
    logic                    frame_start;
    logic [3:0]              digit_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   an_next;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_digit;
    logic [6:0]              cur_seg;
    logic [6:0]              seg_next;

    assign tick        = (presc_reg == PW'(REFRESH_DIV - 1));
    assign frame_start = (presc_reg == '0) && (index_reg == '0);

    // Unpack the snapshot into per-digit nibbles and build the one-hot-low anode pattern.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_val[gi] = snap_digits_reg[4*gi +: 4];
            assign an_next[gi]   = (index_reg != IW'(gi));
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // lz_mask[k] is set when digit k and every digit above it are zero;
    // digit 0 is never suppressed so a zero value still shows "0".
    assign lz_mask[NUM_DIGITS-1] = (digit_val[NUM_DIGITS-1] == 4'd0);
    assign lz_mask[0]            = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_DIGITS - 1; gi++) begin : g_lz
            assign lz_mask[gi] = (digit_val[gi] == 4'd0) && lz_mask[gi+1];
        end
    endgenerate
`else
    assign lz_mask = '0;
`endif

    assign cur_digit = digit_val[index_reg];

    bcd_to_7seg u_dec (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    // Segment pattern for the currently scanned digit, after leading-zero suppression.
    always_comb begin
        seg_next = cur_seg;
        if (lz_mask[index_reg]) begin
            seg_next = SEG_BLANK;
        end
    end

    // Refresh prescaler and digit-scan index.
    always_ff @(posedge clk) begin
        if (Clr) begin
            presc_reg <= '0;
            index_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
            index_reg <= (index_reg == IW'(NUM_DIGITS - 1)) ? '0 : index_reg + 1'b1;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // Frame-coherent snapshot of the digit and decimal-point inputs.
    always_ff @(posedge clk) begin
        if (Clr) begin
            snap_digits_reg <= '0;
            snap_dp_reg     <= '0;
        end else if (frame_start) begin
            snap_digits_reg <= Digits;
            snap_dp_reg     <= DpIn;
        end
    end

    // Registered pin drive; Blank only gates the outputs, the scan keeps running.
    always_ff @(posedge clk) begin
        if (Clr) begin
            seg_reg        <= SEG_BLANK;
            dp_reg         <= 1'b1;
            an_reg         <= '1;
            frame_tick_reg <= 1'b0;
        end else begin
            frame_tick_reg <= frame_start;
            if (Blank) begin
                seg_reg <= SEG_BLANK;
                dp_reg  <= 1'b1;
                an_reg  <= '1;
            end else begin
                seg_reg <= seg_next;
                dp_reg  <= ~snap_dp_reg[index_reg];
                an_reg  <= an_next;
            end
        end
    end

    assign Seg       = seg_reg;
    assign Dp        = dp_reg;
    assign An        = an_reg;
    assign FrameTick = frame_tick_reg;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display (NUM_DIGITS=4, REFRESH_DIV=4).
// A frame-position model predicts every registered output each cycle;
// hand-computed literals pin both the DUT and the model at key points.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
`timescale 1ns/1ps
module tb_bcd_scan_display;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int FRAME = N * R;

    logic           clk = 1'b0;
    logic           Clr;
    logic [4*N-1:0] Digits;
    logic [N-1:0]   DpIn;
    logic           Blank;
    logic [6:0]     Seg;
    logic           Dp;
    logic [N-1:0]   An;
    logic           FrameTick;

    always #5 clk = ~clk;

    bcd_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
        .clk       (clk),
        .Clr       (Clr),
        .Digits    (Digits),
        .DpIn      (DpIn),
        .Blank     (Blank),
        .Seg       (Seg),
        .Dp        (Dp),
        .An        (An),
        .FrameTick (FrameTick)
    );

    int checks = 0;
    int passes = 0;

    // Reference segment table written straight from the digit glyphs.
    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Behavioural model: outputs follow from the number of cycles since reset.
    int             n;
    logic [4*N-1:0] m_snap;
    logic [N-1:0]   m_dp;
    logic [6:0]     exp_seg;
    logic           exp_dp;
    logic [N-1:0]   exp_an;
    logic           exp_ft;
    bit             model_valid = 1'b0;

    always @(posedge clk) begin
        int pos;
        int idx;
        logic [4*N-1:0] upper;
        if (Clr) begin
            n       = 0;
            m_snap  = '0;
            m_dp    = '0;
            exp_seg = 7'b1111111;
            exp_dp  = 1'b1;
            exp_an  = '1;
            exp_ft  = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            pos    = n % FRAME;
            idx    = pos / R;
            exp_ft = (pos == 0);
            upper  = m_snap >> (4 * idx);
            if (Blank) begin
                exp_an  = '1;
                exp_seg = 7'b1111111;
                exp_dp  = 1'b1;
            end else begin
                exp_an      = '1;
                exp_an[idx] = 1'b0;
                exp_seg     = ref_seg(int'(upper[3:0]));
`ifdef LEADING_ZERO_BLANK_EN
                if (idx > 0 && upper == '0) exp_seg = 7'b1111111;
`endif
                exp_dp = ~m_dp[idx];
            end
            if (pos == 0) begin
                m_snap = Digits;
                m_dp   = DpIn;
            end
            n++;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (An !== exp_an || Seg !== exp_seg || Dp !== exp_dp || FrameTick !== exp_ft) begin
                $display("FAIL cycle_compare t=%0t got An=%b Seg=%b Dp=%b FrameTick=%b required An=%b Seg=%b Dp=%b FrameTick=%b",
                         $time, An, Seg, Dp, FrameTick, exp_an, exp_seg, exp_dp, exp_ft);
            end else begin
                passes++;
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) $display("FAIL %s: got %b required %b", name, act, req);
        else passes++;
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_ft(input int maxc);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (FrameTick !== 1'b1 && c < maxc);
        check_val("wait_frametick", 32'(FrameTick), 32'd1);
    endtask

    task automatic wait_an(input logic [N-1:0] v, input int maxc);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (An !== v && c < maxc);
        check_val("wait_anode", 32'(An), 32'(v));
    endtask

    logic [6:0] upper_zero_seg;

    initial begin
`ifdef LEADING_ZERO_BLANK_EN
        upper_zero_seg = 7'b1111111;
`else
        upper_zero_seg = 7'b1000000;
`endif
        Clr = 1'b1; Digits = 16'h1234; DpIn = '0; Blank = 1'b0;
        cyc(3);
        check_val("reset_an",  32'(An), 32'b1111);
        check_val("reset_seg", 32'(Seg), 32'b1111111);
        check_val("reset_dp",  32'(Dp), 32'd1);
        check_val("reset_ft",  32'(FrameTick), 32'd0);

        // First frame after reset: cleared snapshot shows "0", then captured "4".
        Clr = 1'b0;
        cyc(1);
        check_val("c1_an",        32'(An), 32'b1110);
        check_val("c1_seg",       32'(Seg), 32'b1000000);
        check_val("c1_model_seg", 32'(exp_seg), 32'b1000000);
        check_val("c1_ft",        32'(FrameTick), 32'd1);
        cyc(1);
        check_val("c2_seg", 32'(Seg), 32'b0011001);
        cyc(3);
        check_val("c5_an",        32'(An), 32'b1101);
        check_val("c5_seg",       32'(Seg), 32'b0110000);
        check_val("c5_model_seg", 32'(exp_seg), 32'b0110000);
        cyc(40);

        // Mid-frame change must not tear the displayed value.
        wait_ft(40);
        cyc(2);
        Digits = 16'h5678;
        wait_ft(40);
        check_val("tear_old_d0", 32'(Seg), 32'b0011001);
        cyc(1);
        check_val("tear_new_d0", 32'(Seg), 32'b0000000);
        cyc(20);

        // Non-BCD digit, decimal point, and leading zeros.
        Digits = 16'h00A9; DpIn = 4'b0010;
        wait_ft(40);
        // Frame-start cycle still shows digit 0 of the previous snapshot (8).
        check_val("a9_d0_seg", 32'(Seg), 32'b0000000);
        wait_an(4'b1110, 20);
        cyc(1);
        check_val("a9_d0_nine", 32'(Seg), 32'b0010000);
        wait_an(4'b1101, 20);
        check_val("a9_d1_dash", 32'(Seg), 32'b0111111);
        check_val("a9_d1_dp",   32'(Dp), 32'd0);
        wait_an(4'b1011, 20);
        check_val("a9_d2_zero", 32'(Seg), 32'(upper_zero_seg));
        wait_an(4'b0111, 20);
        check_val("a9_d3_zero", 32'(Seg), 32'(upper_zero_seg));
        cyc(5);

        // Blank for 10 cycles mid-frame.
        Blank = 1'b1;
        cyc(1);
        check_val("blank_an",  32'(An), 32'b1111);
        check_val("blank_seg", 32'(Seg), 32'b1111111);
        check_val("blank_dp",  32'(Dp), 32'd1);
        cyc(9);
        Blank = 1'b0;
        cyc(20);

        // Randomised stimulus including rare resets and blanking.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) Digits = 16'($urandom);
            if ($urandom_range(0, 7) == 0) DpIn = 4'($urandom);
            if ($urandom_range(0, 11) == 0) Blank = ~Blank;
            Clr = ($urandom_range(0, 149) == 0);
            cyc(1);
        end
        Clr = 1'b0; Blank = 1'b0; Digits = 16'h4321; DpIn = 4'b0101;
        cyc(40);

        // Reset while digit 2 is lit.
        wait_an(4'b1011, 40);
        Clr = 1'b1;
        cyc(1);
        check_val("clr_an",  32'(An), 32'b1111);
        check_val("clr_seg", 32'(Seg), 32'b1111111);
        check_val("clr_ft",  32'(FrameTick), 32'd0);
        Clr = 1'b0;
        cyc(1);
        check_val("clr_restart_an", 32'(An), 32'b1110);
        check_val("clr_restart_ft", 32'(FrameTick), 32'd1);
        cyc(1);
        check_val("clr_reload_seg", 32'(Seg), 32'b1111001);
        cyc(40);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
